regfile_sb: RTL

//  Integer register file answering the decode stage's two read requests, taking the

---
 rtl/regfile_sb_pkg.sv | 24 ++
 rtl/regfile_sb_rport.sv | 38 +++
 rtl/regfile_sb.sv | 102 ++++++++++
 3 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared constants and types for the integer register file with load scoreboard.
// Widths, reset/enable levels and the zero register live here so every file agrees.
package regfile_sb_pkg;

    localparam int REG_NUM = 32;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;

    localparam logic [ADDR_W-1:0] ZERO_REG     = '0;
    localparam logic [DATA_W-1:0] ZERO_WORD    = '0;
    localparam logic              RST_ENABLE   = 1'b1;
    localparam logic              READ_ENABLE  = 1'b1;
    localparam logic              WRITE_ENABLE = 1'b1;

    typedef logic [DATA_W-1:0] reg_word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    // A write-back to the address being read this cycle.
    function automatic logic wb_hit(input logic we, input reg_addr_t waddr,
                                    input reg_addr_t raddr);
        return (we == WRITE_ENABLE) && (waddr == raddr);
    endfunction

endpackage

// File: rtl/regfile_sb_rport.sv
// One read port: priority mux (reset, enable, x0/range, bypass, storage) and the
// load-use busy flag for that port.
module regfile_rport
    import regfile_sb_pkg::*;
(
    input  logic      rst_i,
    input  logic      re_i,
    input  reg_addr_t raddr_i,
    input  logic      addr_ok_i,
    input  logic      we_i,
    input  reg_addr_t waddr_i,
    input  reg_word_t wdata_i,
    input  reg_word_t stored_i,
    input  logic      busy_bit_i,
    output reg_word_t rdata_o,
    output logic      busy_o
);

    logic bypass;
    logic active;

    assign bypass = wb_hit(we_i, waddr_i, raddr_i);
    assign active = (rst_i != RST_ENABLE) && (re_i == READ_ENABLE) && addr_ok_i;

    // addr_ok_i already excludes x0 and unmapped addresses, so a bypass can only
    // forward to a real register.
    always_comb begin
        rdata_o = ZERO_WORD;
        if (active) begin
            if (bypass) rdata_o = wdata_i;
            else        rdata_o = stored_i;
        end
    end

    // Same-cycle write-back satisfies the reader, so it never stalls.
    assign busy_o = active && busy_bit_i && !bypass;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports, write-back bypass and a
// per-register busy scoreboard for outstanding loads.
module regfile_sb
    import regfile_sb_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      reg1_re_i,
    input  reg_addr_t reg1_raddr_i,
    output reg_word_t reg1_rdata_o,
    output logic      reg1_busy_o,
    input  logic      reg2_re_i,
    input  reg_addr_t reg2_raddr_i,
    output reg_word_t reg2_rdata_o,
    output logic      reg2_busy_o,
    input  logic      we_i,
    input  reg_addr_t waddr_i,
    input  reg_word_t wdata_i,
    input  logic      sb_set_i,
    input  reg_addr_t sb_addr_i
);

    localparam int ADDR_SPACE = 2 ** ADDR_W;

    reg_word_t          regs [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_next;

    // in_range marks addresses that name a writable register: not x0, below REG_NUM.
    logic [ADDR_SPACE-1:0] in_range;

    for (genvar i = 0; i < ADDR_SPACE; i++) begin : g_range
        assign in_range[i] = (i != 0) && (i < REG_NUM);
    end

    logic wr_ok;
    logic set_ok;
    logic ok1, ok2;

    assign wr_ok  = (we_i == WRITE_ENABLE) && in_range[waddr_i];
    assign set_ok = sb_set_i && in_range[sb_addr_i];
    assign ok1    = in_range[reg1_raddr_i];
    assign ok2    = in_range[reg2_raddr_i];

    always_ff @(posedge clk_i) begin
        if (rst_i == RST_ENABLE) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= ZERO_WORD;
        end else if (wr_ok) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    // Set is applied after clear so a new load to the same rd keeps ownership.
    always_comb begin
        busy_next = busy_q;
        if (wr_ok)  busy_next[waddr_i]   = 1'b0;
        if (set_ok) busy_next[sb_addr_i] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i == RST_ENABLE) busy_q <= '0;
        else                     busy_q <= busy_next;
    end

    reg_word_t stored1, stored2;
    logic      busy_bit1, busy_bit2;

    assign stored1   = ok1 ? regs[reg1_raddr_i]   : ZERO_WORD;
    assign stored2   = ok2 ? regs[reg2_raddr_i]   : ZERO_WORD;
    assign busy_bit1 = ok1 ? busy_q[reg1_raddr_i] : 1'b0;
    assign busy_bit2 = ok2 ? busy_q[reg2_raddr_i] : 1'b0;

    regfile_rport u_rport1 (
        .rst_i      (rst_i),
        .re_i       (reg1_re_i),
        .raddr_i    (reg1_raddr_i),
        .addr_ok_i  (ok1),
        .we_i       (we_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .stored_i   (stored1),
        .busy_bit_i (busy_bit1),
        .rdata_o    (reg1_rdata_o),
        .busy_o     (reg1_busy_o)
    );

    regfile_rport u_rport2 (
        .rst_i      (rst_i),
        .re_i       (reg2_re_i),
        .raddr_i    (reg2_raddr_i),
        .addr_ok_i  (ok2),
        .we_i       (we_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .stored_i   (stored2),
        .busy_bit_i (busy_bit2),
        .rdata_o    (reg2_rdata_o),
        .busy_o     (reg2_busy_o)
    );

endmodule
